// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared definitions for the traffic phase controller.
//               - Phase state encoding (GREEN / YELLOW / OVR)
//               - Default timing constants
//               - Lowest-set-bit priority encoder for override selection
//               - Width helper for the idle counter
// Revision    : 1.0 - initial multi-approach release
// ============================================================================
package traffic_pkg;

    // Phase state encoding
    localparam logic [1:0] ST_GREEN  = 2'd0;
    localparam logic [1:0] ST_YELLOW = 2'd1;
    localparam logic [1:0] ST_OVR    = 2'd2;

    // Default timing constants
    localparam int c_def_num_appr = 2;
    localparam int c_def_cnt_w    = 7;
    localparam int c_def_green_t  = 90;
    localparam int c_def_yellow_t = 5;
    localparam int c_def_idle_t   = 5;

    // Widest override vector the priority encoder accepts
    localparam int c_max_appr = 32;

    // Index of the lowest set bit; 0 when no bit is set (callers gate on |v).
    function automatic int unsigned lowest_set(input logic [c_max_appr-1:0] v);
        int unsigned idx;
        idx = 0;
        for (int i = c_max_appr - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    // Idle counter width: enough to hold IDLE_T, never narrower than one bit
    // so that IDLE_T=0 (early-out disabled) still elaborates.
    function automatic int idle_cnt_w(input int t);
        return (t <= 0) ? 1 : $clog2(t + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_idle_cnt.sv
`default_nettype none
// ============================================================================
// Module      : traffic_idle_cnt
// Description : Saturating counter of consecutive empty-road ticks for the
//               approach currently being served.
//   CLK   in  1  system clock
//   R     in  1  asynchronous active-high reset
//   clr   in  1  synchronous clear (priority over en)
//   en    in  1  count enable (timebase tick)
//   empty in  1  1 = no vehicle on the monitored approach
//   hit   out 1  this tick makes the count reach IDLE_T (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_idle_cnt
    import traffic_pkg::*;
#(
    parameter int IDLE_T = c_def_idle_t
) (
    input  logic CLK,
    input  logic R,
    input  logic clr,
    input  logic en,
    input  logic empty,
    output logic hit
);

    localparam int             c_w    = idle_cnt_w(IDLE_T);
    localparam logic [c_w-1:0] c_max  = c_w'(IDLE_T);
    localparam logic [c_w-1:0] c_last = (IDLE_T > 0) ? c_w'(IDLE_T - 1) : '0;

    logic [c_w-1:0] r_cnt;

    // hit deliberately ignores clr: the parent derives clr from hit.
    assign hit = (IDLE_T != 0) && en && empty && (r_cnt == c_last);

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (!empty) begin
                r_cnt <= '0;
            end else if (r_cnt != c_max) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : traffic_phase_ctrl
// Description : Round-robin green/yellow phase controller for NUM_APPR
//               approaches with max-green timeout, idle early-out and
//               per-approach manual override.
//   CLK      in  1         system clock
//   R        in  1         asynchronous active-high reset
//   tick     in  1         timebase enable, timers advance only when high
//   traffic  in  NUM_APPR  presence sensor per approach
//   override in  NUM_APPR  force-green request per approach (level)
//   green    out NUM_APPR  one-hot green lamp, registered
//   yellow   out NUM_APPR  one-hot yellow lamp, registered
//   second   out CNT_W     ticks elapsed in current phase, registered
//   active   out IDX_W     index of approach currently served, registered
// Revision    : 1.0 - initial multi-approach release
// ============================================================================
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int NUM_APPR = c_def_num_appr,
    parameter int CNT_W    = c_def_cnt_w,
    parameter int GREEN_T  = c_def_green_t,
    parameter int YELLOW_T = c_def_yellow_t,
    parameter int IDLE_T   = c_def_idle_t,
    parameter int IDX_W    = $clog2(NUM_APPR)
) (
    input  logic                CLK,
    input  logic                R,
    input  logic                tick,
    input  logic [NUM_APPR-1:0] traffic,
    input  logic [NUM_APPR-1:0] override,
    output logic [NUM_APPR-1:0] green,
    output logic [NUM_APPR-1:0] yellow,
    output logic [CNT_W-1:0]    second,
    output logic [IDX_W-1:0]    active
);

    localparam logic [CNT_W-1:0] c_green_last  = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] c_yellow_last = CNT_W'(YELLOW_T - 1);
    localparam logic [IDX_W-1:0] c_last_appr   = IDX_W'(NUM_APPR - 1);

    function automatic logic [NUM_APPR-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_APPR-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    logic [1:0]            r_state;
    logic [IDX_W-1:0]      r_active;
    logic [CNT_W-1:0]      r_second;
    logic [NUM_APPR-1:0]   r_green;
    logic [NUM_APPR-1:0]   r_yellow;

    logic [1:0]            w_state_nxt;
    logic [IDX_W-1:0]      w_active_nxt;
    logic [CNT_W-1:0]      w_second_nxt;
    logic [NUM_APPR-1:0]   w_green_nxt;
    logic [NUM_APPR-1:0]   w_yellow_nxt;

    logic [c_max_appr-1:0] w_ovr_ext;
    logic                  w_ovr_any;
    logic [IDX_W-1:0]      w_ovr_idx;
    logic                  w_idle_hit;
    logic                  w_green_done;
    logic                  w_yellow_done;
    logic                  w_idle_clr;

    // Override decode: lowest requesting approach wins
    always_comb begin
        w_ovr_ext               = '0;
        w_ovr_ext[NUM_APPR-1:0] = override;
    end

    assign w_ovr_any = |override;
    assign w_ovr_idx = IDX_W'(lowest_set(w_ovr_ext));

    // Phase end conditions; both may coincide, giving a single transition
    assign w_green_done  = tick && ((r_second == c_green_last) || w_idle_hit);
    assign w_yellow_done = tick && (r_second == c_yellow_last);

    // Idle count only accumulates while serving a normal green phase
    assign w_idle_clr = w_ovr_any || (r_state != ST_GREEN) || w_green_done;

    traffic_idle_cnt #(
        .IDLE_T (IDLE_T)
    ) u_idle_cnt (
        .CLK   (CLK),
        .R     (R),
        .clr   (w_idle_clr),
        .en    (tick),
        .empty (~traffic[r_active]),
        .hit   (w_idle_hit)
    );

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_active_nxt = r_active;
        w_second_nxt = r_second;

        if (w_ovr_any) begin
            w_state_nxt  = ST_OVR;
            w_active_nxt = w_ovr_idx;
            w_second_nxt = '0;
        end else begin
            case (r_state)
                ST_OVR: begin
                    // Release goes straight to green on the forced approach
                    w_state_nxt  = ST_GREEN;
                    w_second_nxt = '0;
                end
                ST_GREEN: begin
                    if (w_green_done) begin
                        w_state_nxt  = ST_YELLOW;
                        w_second_nxt = '0;
                    end else if (tick) begin
                        w_second_nxt = r_second + 1'b1;
                    end
                end
                ST_YELLOW: begin
                    if (w_yellow_done) begin
                        w_state_nxt  = ST_GREEN;
                        w_second_nxt = '0;
                        w_active_nxt = (r_active == c_last_appr) ? '0 : r_active + 1'b1;
                    end else if (tick) begin
                        w_second_nxt = r_second + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt  = ST_GREEN;
                    w_active_nxt = '0;
                    w_second_nxt = '0;
                end
            endcase
        end

        w_green_nxt  = (w_state_nxt == ST_YELLOW) ? '0 : onehot(w_active_nxt);
        w_yellow_nxt = (w_state_nxt == ST_YELLOW) ? onehot(w_active_nxt) : '0;
    end

    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            r_state  <= ST_GREEN;
            r_active <= '0;
            r_second <= '0;
            r_green  <= onehot('0);
            r_yellow <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= w_active_nxt;
            r_second <= w_second_nxt;
            r_green  <= w_green_nxt;
            r_yellow <= w_yellow_nxt;
        end
    end

    assign green  = r_green;
    assign yellow = r_yellow;
    assign second = r_second;
    assign active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_traffic_phase_ctrl
// Description : Self-checking bench for traffic_phase_ctrl (3 approaches,
//               GREEN_T=10, YELLOW_T=3, IDLE_T=4). Vectors of
//               {inputs, expected outputs} are built per scenario, expected
//               values queued when stimulus is driven and compared after
//               the following clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_ctrl;

    localparam int c_na = 3;
    localparam int c_cw = 7;
    localparam int c_gt = 10;
    localparam int c_yt = 3;
    localparam int c_it = 4;
    localparam int c_iw = 2;

    logic            CLK = 1'b0;
    logic            R;
    logic            tick;
    logic [c_na-1:0] traffic;
    logic [c_na-1:0] override;
    logic [c_na-1:0] green;
    logic [c_na-1:0] yellow;
    logic [c_cw-1:0] second;
    logic [c_iw-1:0] active;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic            tk;
        logic [c_na-1:0] trf;
        logic [c_na-1:0] ovr;
        logic [c_na-1:0] eg;
        logic [c_na-1:0] ey;
        logic [c_cw-1:0] es;
        logic [c_iw-1:0] ea;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    traffic_phase_ctrl #(
        .NUM_APPR (c_na),
        .CNT_W    (c_cw),
        .GREEN_T  (c_gt),
        .YELLOW_T (c_yt),
        .IDLE_T   (c_it),
        .IDX_W    (c_iw)
    ) dut (
        .CLK      (CLK),
        .R        (R),
        .tick     (tick),
        .traffic  (traffic),
        .override (override),
        .green    (green),
        .yellow   (yellow),
        .second   (second),
        .active   (active)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    function automatic logic [c_na-1:0] oh(input int a);
        logic [c_na-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        return v;
    endfunction

    // Expected outputs after the edge that consumes these inputs
    function automatic void add(input logic tk, input logic [c_na-1:0] trf,
                                input logic [c_na-1:0] ovr, input int appr,
                                input bit is_yel, input int s);
        vec_t v;
        v.tk  = tk;
        v.trf = trf;
        v.ovr = ovr;
        v.eg  = is_yel ? '0 : oh(appr);
        v.ey  = is_yel ? oh(appr) : '0;
        v.es  = c_cw'(s);
        v.ea  = c_iw'(appr);
        tbl.push_back(v);
    endfunction

    // Full round-robin cycle from reset release with steady traffic
    function automatic void build_cycle();
        for (int a = 0; a < c_na; a++) begin
            for (int s = (a == 0) ? 1 : 0; s < c_gt; s++) add(1'b1, 3'b111, 3'b000, a, 1'b0, s);
            for (int s = 0; s < c_yt; s++) add(1'b1, 3'b111, 3'b000, a, 1'b1, s);
        end
        add(1'b1, 3'b111, 3'b000, 0, 1'b0, 0);
    endfunction

    task automatic check(input string nm, input logic [c_na-1:0] eg, input logic [c_na-1:0] ey,
                         input logic [c_cw-1:0] es, input logic [c_iw-1:0] ea);
        n_checks++;
        if ({green, yellow, second, active} !== {eg, ey, es, ea}) begin
            n_fail++;
            $display("FAIL %s: got green=%b yellow=%b second=%0d active=%0d, expected green=%b yellow=%b second=%0d active=%0d",
                     nm, green, yellow, second, active, eg, ey, es, ea);
        end
        n_checks++;
        if (!$onehot(green | yellow) || ((green & yellow) != '0)) begin
            n_fail++;
            $display("FAIL %s_lamp_excl: got green=%b yellow=%b, expected exactly one lamp bit", nm, green, yellow);
        end
    endtask

    task automatic run_table(input string nm);
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            tick     = tbl[i].tk;
            traffic  = tbl[i].trf;
            override = tbl[i].ovr;
            sb.push_back(tbl[i]);
            @(posedge CLK);
            #1;
            e = sb.pop_front();
            check($sformatf("%s[%0d]", nm, i), e.eg, e.ey, e.es, e.ea);
        end
        tbl.delete();
    endtask

    // Assert reset between edges, confirm it acts immediately, release
    // between edges so the next edge is the first functional one.
    task automatic do_reset(input string nm);
        tick     = 1'b1;
        traffic  = 3'b111;
        override = 3'b000;
        R        = 1'b1;
        #1;
        check({nm, "_async"}, 3'b001, 3'b000, 0, 0);
        @(posedge CLK);
        #1;
        check({nm, "_held"}, 3'b001, 3'b000, 0, 0);
        R = 1'b0;
    endtask

    initial begin
        int cnt;
        bit done;
        R        = 1'b0;
        tick     = 1'b0;
        traffic  = 3'b111;
        override = 3'b000;
        #2;

        // 1: plain round robin
        do_reset("rst1");
        build_cycle();
        run_table("cycle");

        // 2: approach 0 empty, idle early-out after 4 ticks
        do_reset("rst2");
        for (int s = 1; s <= 3; s++) add(1'b1, 3'b110, 3'b000, 0, 1'b0, s);
        for (int s = 0; s < c_yt; s++) add(1'b1, 3'b110, 3'b000, 0, 1'b1, s);
        add(1'b1, 3'b110, 3'b000, 1, 1'b0, 0);
        run_table("idle");

        // 2b: a vehicle mid-run restarts the idle count
        do_reset("rst2b");
        for (int s = 1; s <= 3; s++) add(1'b1, 3'b110, 3'b000, 0, 1'b0, s);
        add(1'b1, 3'b111, 3'b000, 0, 1'b0, 4);
        for (int s = 5; s <= 7; s++) add(1'b1, 3'b110, 3'b000, 0, 1'b0, s);
        add(1'b1, 3'b110, 3'b000, 0, 1'b1, 0);
        run_table("idle_restart");

        // 3: override mid-green, hold, release without yellow
        do_reset("rst3");
        for (int s = 1; s <= 5; s++) add(1'b1, 3'b111, 3'b000, 0, 1'b0, s);
        for (int i = 0; i < 21; i++) add(1'b1, 3'b111, 3'b100, 2, 1'b0, 0);
        for (int s = 0; s < c_gt; s++) add(1'b1, 3'b111, 3'b000, 2, 1'b0, s);
        for (int s = 0; s < c_yt; s++) add(1'b1, 3'b111, 3'b000, 2, 1'b1, s);
        add(1'b1, 3'b111, 3'b000, 0, 1'b0, 0);
        run_table("ovr");

        // 4: lowest index wins, retarget, override acts with tick low
        add(1'b0, 3'b111, 3'b110, 1, 1'b0, 0);
        add(1'b0, 3'b111, 3'b100, 2, 1'b0, 0);
        add(1'b0, 3'b111, 3'b000, 2, 1'b0, 0);
        add(1'b1, 3'b111, 3'b000, 2, 1'b0, 1);
        add(1'b0, 3'b111, 3'b000, 2, 1'b0, 1);
        run_table("ovr_prio");

        // 5: sparse tick, yellow on the 10th tick
        do_reset("rst5");
        cnt  = 0;
        done = 1'b0;
        for (int i = 0; !done && i < 100; i++) begin
            if ((i % 4) == 3) begin
                if (cnt == c_gt - 1) begin
                    add(1'b1, 3'b111, 3'b000, 0, 1'b1, 0);
                    done = 1'b1;
                end else begin
                    cnt++;
                    add(1'b1, 3'b111, 3'b000, 0, 1'b0, cnt);
                end
            end else begin
                add(1'b0, 3'b111, 3'b000, 0, 1'b0, cnt);
            end
        end
        add(1'b1, 3'b111, 3'b000, 0, 1'b1, 1);
        add(1'b1, 3'b111, 3'b000, 0, 1'b1, 2);
        add(1'b1, 3'b111, 3'b000, 1, 1'b0, 0);
        run_table("sparse_tick");

        // 6: asynchronous reset during yellow of approach 1
        do_reset("rst6");
        build_cycle();
        while (tbl.size() > 24) void'(tbl.pop_back());
        run_table("pre_rst");
        #2;
        R = 1'b1;
        #1;
        check("mid_yellow_rst", 3'b001, 3'b000, 0, 0);
        @(posedge CLK);
        #1;
        R = 1'b0;
        for (int s = 1; s <= 3; s++) add(1'b1, 3'b111, 3'b000, 0, 1'b0, s);
        run_table("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Parametrised multi-approach traffic-light phase controller; successor to the two-approach Moore controller.
- Cycles green then yellow through NUM_APPR approaches in round-robin order.
- Each green phase has a maximum time. It ends early after IDLE_T consecutive empty-road ticks.
- Per-approach manual override forces one approach green. Sits between sensor/button inputs and the lamp drivers / BCD display path (via second).

Parameters:
NUM_APPR, 2, number of approaches (>=2)
CNT_W, 7, width of phase timer / second output
GREEN_T, 90, max green duration in ticks (1..2^CNT_W-1)
YELLOW_T, 5, yellow duration in ticks (1..2^CNT_W-1)
IDLE_T, 5, consecutive idle ticks that end green early; 0 disables early-out
IDX_W, $clog2(NUM_APPR), width of active index

Ports:
CLK  in  1  system clock, all state on posedge
R  in  1  reset, asynchronous, active-high
tick  in  1  timebase enable (one pulse per second); timers advance only when high
traffic  in  NUM_APPR  presence sensor per approach, 1 = vehicle present
override  in  NUM_APPR  manual force-green request per approach, level-sensitive
green  out  NUM_APPR  one-hot green lamp, registered
yellow  out  NUM_APPR  one-hot yellow lamp, registered
second  out  CNT_W  ticks elapsed in current phase, registered
active  out  IDX_W  index of approach currently served

Behaviour:

Reset (R=1, asynchronous):
- state=GREEN, active=0, green=1 at bit 0 only, yellow=0, second=0, idle counter=0.
- Reset dominates all inputs. Release takes effect on the next CLK edge.

All outputs change only on a CLK posedge, one cycle after the qualifying input.

States: GREEN, YELLOW, OVR. Priority each edge is R > override > timing.

Override:
- If any override bit is set, select the lowest set index k. Go to OVR with active=k, green=onehot(k), yellow=0, second=0, idle=0.
- This happens regardless of tick or current state.
- In OVR, second holds at 0. A change of the lowest set bit retargets k on the next edge.

OVR exit:
- When override returns to 0, enter GREEN with active=k unchanged, second=0.
- No yellow is inserted.

GREEN:
- On tick: second+=1.
- Idle counter: +1 if traffic[active]==0, cleared if traffic[active]==1.
- Transition to YELLOW (same active, green=0, yellow=onehot(active), second=0, idle=0) on a tick edge when either condition holds:
  - second==GREEN_T-1, or
  - IDLE_T!=0 and the idle counter would reach IDLE_T on this tick.
- If both conditions hit on the same tick, there is a single transition.

YELLOW:
- On tick: second+=1.
- At second==YELLOW_T-1 with tick, go to GREEN with active=(active==NUM_APPR-1)?0:active+1, second=0.

Invariants:
- At most one bit of green|yellow is set; exactly one is set outside reset.
- green and yellow are never set in the same cycle.

Width rules:
- second never wraps; it is bounded by GREEN_T-1 / YELLOW_T-1.
- Idle counter width is $clog2(IDLE_T+1) and it saturates.

tick=0: state, second and idle counter hold; only override and R act.

Decomposition:
- Shared package traffic_pkg:
  - state encoding constants ST_GREEN/ST_YELLOW/ST_OVR
  - default timing constants
  - lowest-set-bit priority-encoder function used for override
- One sub-module, traffic_idle_cnt: saturating consecutive-idle counter with clear, enable (tick) and the threshold-hit output. It replaces the earlier per-approach flag counters; only one instance is needed because only the active approach is monitored.

Test Plan (NUM_APPR=3, GREEN_T=10, YELLOW_T=3, IDLE_T=4, tick=1 every cycle, traffic=3'b111 unless stated):
1. Release R, no override -> green=001 with second 0..9 over 10 cycles; yellow=001 for 3 cycles; then green=010, then 100; green=001 again at cycle 39.
2. traffic=3'b110 from reset release -> green[0] ends after 4 ticks (second reaches 3); yellow=001 on cycle 4; green=010 on cycle 7.
3. Set override=3'b100 when green=001 and second=5 -> next edge green=100, yellow=000, second=0, active=2. Hold 20 cycles: second stays 0. Clear override -> green[2] counts 0..9, then yellow=100, then green=001.
4. Set override=3'b110 -> green=010, active=1 (lowest index wins). Change to 3'b100 -> next edge green=100.
5. Toggle tick every 4th cycle during GREEN -> second increments only on tick cycles; yellow entry is delayed to the 10th tick.
6. Assert R mid-YELLOW (yellow=010, second=1) between clock edges -> green=001, yellow=000, second=0, active=0 immediately, before any CLK edge. After release, normal cycling resumes from approach 0.
